regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised register file for the ID/WB stages. It has two combinational read ports with same-cycle write-back bypass, one write-back port, and a per-address synchronous clear. A per-register outstanding-write counter (scoreboard) lets the hazard unit detect RAW dependencies on `src1`/`src2` and throttle issue when a destination's counter saturates. All state updates on the rising edge of `clk`.

## Interface
- `WORD_LEN`, 32, data width in bits.
- `WORD_COUNT`, 15, number of registers; need not be a power of two.
- `ADDR_W`, `$clog2(WORD_COUNT)`, address width (derived, not overridden).
- `PEND_W`, 2, width of each outstanding-write counter; max pending = 2^PEND_W − 1.
- `RESET_INDEX`, 1, reset contents: 1 → register i holds i; 0 → all zero.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `src1`, `src2`  in  ADDR_W  read addresses.
- `reg1`, `reg2`  out  WORD_LEN  read data, with bypass.
- `busy1`, `busy2`  out  1  source has a pending write not satisfied this cycle.
- `wb_en`  in  1  write-back enable.
- `wb_dest`  in  ADDR_W  write-back address.
- `wb_data`  in  WORD_LEN  write-back data.
- `sclr`  in  1  synchronous clear of register `wb_dest`.
- `issue_valid`  in  1  an instruction writing `issue_dest` is issuing.
- `issue_dest`  in  ADDR_W  destination of the issuing instruction.
- `issue_ready`  out  1  issue can be accepted this cycle.
- `flush`  in  1  zero all pending counters (pipeline flush).

## Operation
- Reset (`rst_n` = 0, asynchronous):
  - register i ← (`RESET_INDEX` ? i : 0);
  - all counters ← 0.
  - Output values follow the combinational rules below. With `RESET_INDEX` = 1, `reg1` = `src1` and `busy1` = `busy2` = 0. `issue_ready` = 1 if `issue_dest` is in range.
- Write, per address, in priority order:
  1. reset;
  2. `sclr` → register[`wb_dest`] ← 0;
  3. `wb_en` → register[`wb_dest`] ← `wb_data`.
- Read bypass for `regN` (N = 1, 2):
  - `sclr` and `srcN` == `wb_dest` → 0;
  - else `wb_en` and `srcN` == `wb_dest` → `wb_data`;
  - else the stored value.
- Counter (cnt) per address a:
  - inc = `issue_valid` & `issue_ready` & (`issue_dest` == a)
  - dec = `wb_en` & (`wb_dest` == a) & (cnt[a] ≠ 0)
  - next = flush ? 0 : cnt + inc − dec. Simultaneous inc and dec leave cnt unchanged.
  - `sclr` does not touch cnt.
  - `wb_en` to an address with cnt = 0 writes data and leaves cnt at 0 (no underflow).
- `issue_ready` = (cnt[`issue_dest`] ≠ max) or dec[`issue_dest`] this cycle.
  - Saturation is never exceeded.
  - `issue_ready` is independent of `issue_valid`.
- `busyN` = (cnt[`srcN`] − dec[`srcN`]) ≠ 0, evaluated before this cycle's inc. An issue in cycle t sets busy only from cycle t+1.
- `flush` takes priority over same-cycle issue; the issue is dropped. The `wb_en` data write still occurs.
- Out-of-range address (≥ `WORD_COUNT`):
  - reads return 0 and busy 0;
  - writes, `sclr` and issues are ignored;
  - `issue_ready` = 0.

## Timing
- Read and bypass paths are purely combinational, with 0-cycle latency from `src`/`wb_*` to `reg`/`busy`.
- A write at edge t is visible from storage in cycle t+1, and through bypass already in cycle t.
- Counter changes are visible on `busy`/`issue_ready` the cycle after the edge, except for the same-cycle dec term.
- Reset asserted mid-operation immediately forces contents and counters. Release is synchronous to the next rising edge; no writes take effect on the edge where `rst_n` is still low.

## Test plan
- Reset with `RESET_INDEX` = 1, `src1` = 7, `src2` = 14 → `reg1` = 7, `reg2` = 14, `busy1` = `busy2` = 0, `issue_ready` = 1.
- Bypass:
  - `wb_en` = 1, `wb_dest` = 3, `wb_data` = 0xDEADBEEF, `src1` = 3 → `reg1` = 0xDEADBEEF in the same cycle and after the edge.
  - `sclr` and `wb_en` together on address 3 → `reg1` = 0.
- Scoreboard:
  - Issue dest 5 three times (`PEND_W` = 2) → `busy1` (`src1` = 5) = 1 and `issue_ready` = 0 for dest 5.
  - `wb_en` to 5 with a same-cycle issue to 5 → accepted, cnt stays at 3.
  - Three further writes → `busy1` falls in the cycle of the third write.
- `flush` with cnt[2] = 2 and a same-cycle issue to 2 → cnt[2] = 0, `busy` = 0 next cycle.
- Out-of-range `src1` = 15 with `WORD_COUNT` = 15 → `reg1` = 0; a write to 15 leaves registers 0–14 unchanged.
- Assert `rst_n` low mid-sequence with cnt[4] = 1 and register 4 = 0x55 → register 4 = 4 and cnt = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file for the ID/WB stages with a per-register outstanding-write
//   counter used by the hazard unit.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     src1, src2          read addresses
//     reg1, reg2          read data, bypassed from the same-cycle write-back
//     busy1, busy2        source still has a pending write after this cycle's
//                         write-back is taken into account
//     wb_en, wb_dest,
//     wb_data             write-back port
//     sclr                synchronous clear of register wb_dest
//     issue_valid,
//     issue_dest,
//     issue_ready         issue handshake (see below)
//     flush               zero every pending counter
//
//   Issue handshake: an issue is accepted on a rising edge where issue_valid
//   and issue_ready are both high. issue_ready never depends on issue_valid,
//   and a producer may hold issue_valid high while issue_ready is low.
//
//   Out-of-range addresses (>= WORD_COUNT) read as 0 / not busy; writes,
//   clears and issues to them are dropped, and issue_ready is low for them.
module regfile_scoreboard #(
  parameter int WORD_LEN    = 32,
  parameter int WORD_COUNT  = 15,
  parameter int PEND_W      = 2,
  parameter bit RESET_INDEX = 1'b1,
  localparam int ADDR_W     = $clog2(WORD_COUNT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   src1,
  input  logic [ADDR_W-1:0]   src2,
  output logic [WORD_LEN-1:0] reg1,
  output logic [WORD_LEN-1:0] reg2,
  output logic                busy1,
  output logic                busy2,
  input  logic                wb_en,
  input  logic [ADDR_W-1:0]   wb_dest,
  input  logic [WORD_LEN-1:0] wb_data,
  input  logic                sclr,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_dest,
  output logic                issue_ready,
  input  logic                flush
);

  localparam logic [ADDR_W:0]   COUNT_EXT = (ADDR_W + 1)'(WORD_COUNT);
  localparam logic [PEND_W-1:0] CNT_MAX   = '1;

  logic [WORD_LEN-1:0]   mem [WORD_COUNT];
  logic [PEND_W-1:0]     cnt [WORD_COUNT];
  logic [WORD_COUNT-1:0] dec_vec;
  logic [WORD_COUNT-1:0] inc_vec;

  logic [WORD_LEN-1:0] stored1, stored2;
  logic [PEND_W-1:0]   pend1, pend2;
  logic                hit1, hit2;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < COUNT_EXT;
  endfunction

  // A write-back retires one outstanding write, but never below zero.
  always_comb begin
    dec_vec = '0;
    for (int i = 0; i < WORD_COUNT; i++)
      dec_vec[i] = wb_en && (wb_dest == ADDR_W'(i)) && (cnt[i] != '0);
  end

  // Address decode by comparison loop, so out-of-range addresses simply
  // match nothing and fall through to the zero defaults.
  always_comb begin
    stored1     = '0;
    stored2     = '0;
    pend1       = '0;
    pend2       = '0;
    issue_ready = 1'b0;
    for (int i = 0; i < WORD_COUNT; i++) begin
      if (src1 == ADDR_W'(i)) begin
        stored1 = mem[i];
        pend1   = cnt[i] - PEND_W'(dec_vec[i]);
      end
      if (src2 == ADDR_W'(i)) begin
        stored2 = mem[i];
        pend2   = cnt[i] - PEND_W'(dec_vec[i]);
      end
      // A saturated counter still accepts when a write-back retires one
      // entry in the same cycle; the counter then stays at max.
      if (issue_dest == ADDR_W'(i))
        issue_ready = (cnt[i] != CNT_MAX) || dec_vec[i];
    end
  end

  always_comb begin
    hit1  = in_range(src1) && (src1 == wb_dest);
    hit2  = in_range(src2) && (src2 == wb_dest);
    reg1  = (hit1 && sclr) ? '0 : (hit1 && wb_en) ? wb_data : stored1;
    reg2  = (hit2 && sclr) ? '0 : (hit2 && wb_en) ? wb_data : stored2;
    busy1 = (pend1 != '0);
    busy2 = (pend2 != '0);
  end

  // flush drops any same-cycle issue.
  always_comb begin
    inc_vec = '0;
    for (int i = 0; i < WORD_COUNT; i++)
      inc_vec[i] = issue_valid && issue_ready && !flush &&
                   (issue_dest == ADDR_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORD_COUNT; i++)
        mem[i] <= RESET_INDEX ? WORD_LEN'(i) : '0;
    end else begin
      for (int i = 0; i < WORD_COUNT; i++) begin
        if (sclr && (wb_dest == ADDR_W'(i)))
          mem[i] <= '0;
        else if (wb_en && (wb_dest == ADDR_W'(i)))
          mem[i] <= wb_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORD_COUNT; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WORD_COUNT; i++) begin
        if (flush)
          cnt[i] <= '0;
        else if (inc_vec[i] && !dec_vec[i])
          cnt[i] <= cnt[i] + PEND_W'(1);
        else if (dec_vec[i] && !inc_vec[i])
          cnt[i] <= cnt[i] - PEND_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
//   Directed bench for regfile_scoreboard with default parameters
//   (WORD_LEN 32, WORD_COUNT 15, PEND_W 2, RESET_INDEX 1).
module tb_regfile_scoreboard;

  localparam int WL = 32;
  localparam int WC = 15;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] src1, src2;
  logic [WL-1:0] reg1, reg2;
  logic          busy1, busy2;
  logic          wb_en;
  logic [AW-1:0] wb_dest;
  logic [WL-1:0] wb_data;
  logic          sclr;
  logic          issue_valid;
  logic [AW-1:0] issue_dest;
  logic          issue_ready;
  logic          flush;

  int checks   = 0;
  int failures = 0;
  logic [WL-1:0] exp_mem [WC];

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .src1(src1), .src2(src2), .reg1(reg1), .reg2(reg2),
    .busy1(busy1), .busy2(busy2),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data), .sclr(sclr),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .issue_ready(issue_ready), .flush(flush)
  );

  // clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    wb_en = 1'b0; sclr = 1'b0; issue_valid = 1'b0; flush = 1'b0;
    wb_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle();
    src1 = 4'd7; src2 = 4'd14; issue_dest = 4'd0; wb_dest = 4'd0;
    #2 rst_n = 1'b0;
    #2;
    checks++; if (reg1 !== 32'd7) begin failures++; $display("FAIL reset_reg1 got=%0h exp=7", reg1); end
    checks++; if (reg2 !== 32'd14) begin failures++; $display("FAIL reset_reg2 got=%0h exp=e", reg2); end
    checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b exp=00", busy1, busy2); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++; if (reg1 !== 32'd7) begin failures++; $display("FAIL reset_release_reg1 got=%0h exp=7", reg1); end
    for (int i = 0; i < WC; i++) exp_mem[i] = WL'(i);
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_dest = 4'd3; wb_data = 32'hDEADBEEF; src1 = 4'd3; src2 = 4'd4;
    #1;
    checks++; if (reg1 !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_same_cycle got=%0h exp=deadbeef", reg1); end
    checks++; if (reg2 !== 32'd4) begin failures++; $display("FAIL bypass_other_port got=%0h exp=4", reg2); end
    tick(); idle(); #1;
    checks++; if (reg1 !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_stored got=%0h exp=deadbeef", reg1); end
    exp_mem[3] = 32'hDEADBEEF;
    sclr = 1'b1; wb_en = 1'b1; wb_dest = 4'd3; wb_data = 32'h12345678;
    #1;
    checks++; if (reg1 !== 32'd0) begin failures++; $display("FAIL sclr_bypass got=%0h exp=0", reg1); end
    tick(); idle(); #1;
    checks++; if (reg1 !== 32'd0) begin failures++; $display("FAIL sclr_stored got=%0h exp=0", reg1); end
    exp_mem[3] = 32'd0;
    sclr = 1'b1; wb_dest = 4'd6; src2 = 4'd6;
    #1;
    checks++; if (reg2 !== 32'd0) begin failures++; $display("FAIL sclr_port2_bypass got=%0h exp=0", reg2); end
    tick(); idle(); #1;
    checks++; if (reg2 !== 32'd0) begin failures++; $display("FAIL sclr_port2_stored got=%0h exp=0", reg2); end
    exp_mem[6] = 32'd0;
  endtask

  task automatic test_scoreboard();
    idle();
    src1 = 4'd5; src2 = 4'd5; issue_dest = 4'd5; issue_valid = 1'b1;
    #1;
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL sb_busy_before_edge got=%b exp=0", busy1); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL sb_ready_empty got=%b exp=1", issue_ready); end
    tick(); #1;
    checks++; if (busy1 !== 1'b1 || busy2 !== 1'b1) begin failures++; $display("FAIL sb_busy_cnt1 got=%b%b exp=11", busy1, busy2); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL sb_ready_cnt1 got=%b exp=1", issue_ready); end
    tick(); tick(); #1;
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL sb_ready_sat got=%b exp=0", issue_ready); end
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL sb_busy_sat got=%b exp=1", busy1); end
    // held issue while saturated must be refused
    tick();
    wb_en = 1'b1; wb_dest = 4'd5; wb_data = 32'h11;
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL sb_ready_with_dec got=%b exp=1", issue_ready); end
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL sb_busy_with_dec got=%b exp=1", busy1); end
    checks++; if (reg1 !== 32'h11) begin failures++; $display("FAIL sb_bypass got=%0h exp=11", reg1); end
    tick(); idle(); #1;
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL sb_still_sat got=%b exp=0", issue_ready); end
    wb_en = 1'b1; wb_dest = 4'd5; wb_data = 32'h21;
    #1;
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL sb_drain1 got=%b exp=1", busy1); end
    tick(); wb_data = 32'h22; #1;
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL sb_drain2 got=%b exp=1", busy1); end
    tick(); wb_data = 32'h23; #1;
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL sb_drain3_busy got=%b exp=0", busy1); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL sb_drain3_ready got=%b exp=1", issue_ready); end
    tick(); idle(); #1;
    checks++; if (reg1 !== 32'h23) begin failures++; $display("FAIL sb_drain_data got=%0h exp=23", reg1); end
    // write with no pending entry: data lands, counter stays at zero
    wb_en = 1'b1; wb_dest = 4'd5; wb_data = 32'h24;
    tick(); idle(); #1;
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL sb_underflow_busy got=%b exp=0", busy1); end
    checks++; if (reg1 !== 32'h24) begin failures++; $display("FAIL sb_underflow_data got=%0h exp=24", reg1); end
    issue_valid = 1'b1; issue_dest = 4'd5;
    tick(); idle(); #1;
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL sb_after_underflow_busy got=%b exp=1", busy1); end
    wb_en = 1'b1; wb_dest = 4'd5; wb_data = 32'h25;
    tick(); idle(); #1;
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL sb_final_busy got=%b exp=0", busy1); end
    exp_mem[5] = 32'h25;
  endtask

  task automatic test_flush();
    idle();
    issue_dest = 4'd2; issue_valid = 1'b1; src2 = 4'd2;
    tick(); tick(); idle(); #1;
    checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL flush_pre_busy got=%b exp=1", busy2); end
    flush = 1'b1; issue_valid = 1'b1; issue_dest = 4'd2;
    wb_en = 1'b1; wb_dest = 4'd2; wb_data = 32'hABCD;
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", issue_ready); end
    tick(); idle(); #1;
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy2); end
    checks++; if (reg2 !== 32'hABCD) begin failures++; $display("FAIL flush_data got=%0h exp=abcd", reg2); end
    exp_mem[2] = 32'hABCD;
  endtask

  task automatic test_out_of_range();
    idle();
    src1 = 4'd15; issue_dest = 4'd15;
    #1;
    checks++; if (reg1 !== 32'd0 || busy1 !== 1'b0) begin failures++; $display("FAIL oor_read got=%0h/%b exp=0/0", reg1, busy1); end
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL oor_ready got=%b exp=0", issue_ready); end
    wb_en = 1'b1; wb_dest = 4'd15; wb_data = 32'hFFFFFFFF; issue_valid = 1'b1;
    #1;
    checks++; if (reg1 !== 32'd0) begin failures++; $display("FAIL oor_bypass got=%0h exp=0", reg1); end
    tick(); idle();
    sclr = 1'b1; wb_dest = 4'd15;
    tick(); idle();
    for (int i = 0; i < WC; i++) begin
      src1 = AW'(i);
      #1;
      checks++;
      if (reg1 !== exp_mem[i] || busy1 !== 1'b0) begin
        failures++;
        $display("FAIL oor_sweep_%0d got=%0h/%b exp=%0h/0", i, reg1, busy1, exp_mem[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    idle();
    wb_en = 1'b1; wb_dest = 4'd4; wb_data = 32'h55;
    tick(); idle();
    issue_valid = 1'b1; issue_dest = 4'd4;
    tick(); idle();
    src1 = 4'd4;
    #1;
    checks++; if (reg1 !== 32'h55 || busy1 !== 1'b1) begin failures++; $display("FAIL arst_pre got=%0h/%b exp=55/1", reg1, busy1); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (reg1 !== 32'd4) begin failures++; $display("FAIL arst_data got=%0h exp=4", reg1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy1); end
    // an edge while reset is held must not write
    wb_en = 1'b1; wb_dest = 4'd4; wb_data = 32'h99;
    tick(); idle(); #1;
    checks++; if (reg1 !== 32'd4) begin failures++; $display("FAIL arst_write_blocked got=%0h exp=4", reg1); end
    rst_n = 1'b1;
    tick(); #1;
    checks++; if (reg1 !== 32'd4 || busy1 !== 1'b0) begin failures++; $display("FAIL arst_after got=%0h/%b exp=4/0", reg1, busy1); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_scoreboard();
    test_flush();
    test_out_of_range();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
